// File: rtl/timer_array_if.sv
// Register bus between the system bridge and timer_array.
interface timer_array_if;
  logic        sel;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, output we, output addr, output wdata, input rdata);
  modport slave  (input sel, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/timer_array.sv
// Array of NCH independent down-counting timers with per-channel CTRL/PRESET/COUNT
// registers, sticky pending flag and maskable interrupt.
module timer_array #(
  parameter int NCH = 2
) (
  input  logic            clk,
  input  logic            reset,
  timer_array_if.slave    bus,
  output logic [NCH-1:0]  irq
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CNT, ST_INT} state_t;
  typedef enum logic [1:0] {REG_CTRL, REG_PRESET, REG_COUNT, REG_RSVD} reg_t;

  localparam logic [3:0] NCH_L = 4'(NCH);

  logic [2:0] ch_idx;
  reg_t       reg_sel;
  logic       ch_valid;
  logic       wr_en;
  logic       unused_addr;

  assign ch_idx      = bus.addr[6:4];
  assign reg_sel     = reg_t'(bus.addr[3:2]);
  assign ch_valid    = ({1'b0, ch_idx} < NCH_L);
  assign wr_en       = bus.sel & bus.we & ch_valid;
  assign unused_addr = ^{bus.addr[31:7], bus.addr[1:0]};

  // Read views for all 8 decodable channel slots; slots >= NCH read as zero.
  logic [31:0] ctrl_rd   [8];
  logic [31:0] preset_rd [8];
  logic [31:0] count_rd  [8];

  for (genvar i = 0; i < 8; i++) begin : g_ch
    if (i < NCH) begin : g_act
      state_t      state;
      logic        en;
      logic        im;
      logic        pend;
      logic [1:0]  mode;
      logic [31:0] preset;
      logic [31:0] count;
      logic        wr_ctrl;
      logic        wr_preset;

      assign wr_ctrl   = wr_en && (ch_idx == 3'(i)) && (reg_sel == REG_CTRL);
      assign wr_preset = wr_en && (ch_idx == 3'(i)) && (reg_sel == REG_PRESET);

      // Channel FSM plus register writes. Statement order encodes the races:
      // W1C before the FSM so a same-cycle PEND set survives; CTRL write after
      // the FSM so the bus value beats the FSM's EN clear.
      // In auto-reload, INT performs the reload itself (COUNT <= PRESET, on to
      // CNT) so the LOAD-to-LOAD period is PRESET+1, and 2 for PRESET 0 or 1.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state  <= ST_IDLE;
          en     <= 1'b0;
          im     <= 1'b0;
          pend   <= 1'b0;
          mode   <= 2'b00;
          preset <= '0;
          count  <= '0;
        end else begin
          if (wr_ctrl && bus.wdata[4]) pend <= 1'b0;

          case (state)
            ST_IDLE: if (en) state <= ST_LOAD;
            ST_LOAD: begin
              count <= preset;
              state <= ST_CNT;
            end
            ST_CNT: begin
              if (!en) begin
                state <= ST_IDLE;
              end else if (count > 32'd1) begin
                count <= count - 32'd1;
              end else begin
                count <= '0;
                pend  <= 1'b1;
                state <= ST_INT;
              end
            end
            ST_INT: begin
              if (mode == 2'b01) begin
                count <= preset;
                state <= ST_CNT;
              end else begin
                en    <= 1'b0;
                state <= ST_IDLE;
              end
            end
            default: state <= ST_IDLE;
          endcase

          if (wr_ctrl) begin
            en   <= bus.wdata[0];
            mode <= bus.wdata[2:1];
            im   <= bus.wdata[3];
          end
          if (wr_preset) preset <= bus.wdata;
        end
      end

      assign ctrl_rd[i]   = {27'b0, pend, im, mode, en};
      assign preset_rd[i] = preset;
      assign count_rd[i]  = count;
      assign irq[i]       = pend & im;
    end else begin : g_nil
      assign ctrl_rd[i]   = '0;
      assign preset_rd[i] = '0;
      assign count_rd[i]  = '0;
    end
  end

  // Combinational register read for the currently addressed slot.
  always_comb begin
    bus.rdata = '0;
    if (bus.sel && ch_valid) begin
      case (reg_sel)
        REG_CTRL:   bus.rdata = ctrl_rd[ch_idx];
        REG_PRESET: bus.rdata = preset_rd[ch_idx];
        REG_COUNT:  bus.rdata = count_rd[ch_idx];
        default:    bus.rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_array.sv
// Scoreboard bench for timer_array (NCH=2): expectations are queued as each
// scenario is driven and popped as the DUT output is sampled.
module tb_timer_array;

  logic       clk;
  logic       reset;
  logic [1:0] irq;

  timer_array_if bus_if ();

  timer_array #(.NCH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .irq   (irq)
  );

  typedef struct {
    string       nm;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus_if.sel   = 1'b1;
    bus_if.we    = 1'b1;
    bus_if.addr  = a;
    bus_if.wdata = d;
    @(posedge clk);
    #1;
    bus_if.we  = 1'b0;
    bus_if.sel = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus_if.sel = 1'b1;
    bus_if.we  = 1'b0;
    bus_if.addr = a;
    #1;
    d = bus_if.rdata;
  endtask

  task automatic push(input string nm, input logic [31:0] v);
    exp_t e;
    e.nm = nm;
    e.v  = v;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    bus_if.sel = 1'b0;
    bus_if.we  = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] al [6];
    logic [31:0] d;
    exp_t e;
    al = '{32'h00, 32'h04, 32'h08, 32'h10, 32'h14, 32'h18};
    do_reset();
    for (int i = 0; i < 6; i++) push("reset_reg", 32'h0);
    push("reset_irq", 32'h0);
    for (int i = 0; i < 6; i++) begin
      rd(al[i], d);
      e = sb.pop_front();
      total++;
      if (d !== e.v) begin bad++; $display("FAIL %s[%0h]: got %0h want %0h", e.nm, al[i], d, e.v); end
    end
    e = sb.pop_front();
    total++;
    if (32'(irq) !== e.v) begin bad++; $display("FAIL %s: got %0h want %0h", e.nm, irq, e.v); end
  endtask

  task automatic test_one_shot();
    logic [31:0] d;
    exp_t e;
    do_reset();
    bus_write(32'h04, 32'd5);
    bus_write(32'h00, 32'h9);
    for (int k = 5; k >= 0; k--) push("oneshot_count", 32'(k));
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      rd(32'h08, d);
      e = sb.pop_front();
      total++;
      if (d !== e.v) begin bad++; $display("FAIL %s step%0d: got %0d want %0d", e.nm, i, d, e.v); end
    end
    push("oneshot_ctrl_e7", 32'h19);
    rd(32'h00, d);
    e = sb.pop_front();
    total++;
    if (d !== e.v) begin bad++; $display("FAIL %s: got %0h want %0h", e.nm, d, e.v); end
    push("oneshot_irq_e7", 32'h1);
    e = sb.pop_front();
    total++;
    if (32'(irq) !== e.v) begin bad++; $display("FAIL %s: got %0h want %0h", e.nm, irq, e.v); end
    tick();
    push("oneshot_ctrl_e8", 32'h18);
    rd(32'h00, d);
    e = sb.pop_front();
    total++;
    if (d !== e.v) begin bad++; $display("FAIL %s: got %0h want %0h", e.nm, d, e.v); end
    for (int i = 0; i < 3; i++) begin
      tick();
      push("oneshot_count_hold", 32'h0);
      rd(32'h08, d);
      e = sb.pop_front();
      total++;
      if (d !== e.v) begin bad++; $display("FAIL %s: got %0d want %0d", e.nm, d, e.v); end
    end
  endtask

  task automatic test_auto_reload();
    logic [31:0] cs [8];
    logic [31:0] d;
    exp_t e;
    cs = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0};
    do_reset();
    bus_write(32'h14, 32'd3);
    bus_write(32'h10, 32'hB);
    for (int i = 0; i < 8; i++) begin
      push("reload_count", cs[i]);
      push("reload_irq", (i >= 3) ? 32'h2 : 32'h0);
    end
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      rd(32'h18, d);
      e = sb.pop_front();
      total++;
      if (d !== e.v) begin bad++; $display("FAIL %s step%0d: got %0d want %0d", e.nm, i, d, e.v); end
      e = sb.pop_front();
      total++;
      if (32'(irq) !== e.v) begin bad++; $display("FAIL %s step%0d: got %0h want %0h", e.nm, i, irq, e.v); end
    end
    bus_write(32'h10, 32'h1B);
    push("reload_w1c_ctrl", 32'h0B);
    push("reload_w1c_irq", 32'h0);
    push("reload_after_w1c_count", 32'd3);
    rd(32'h10, d);
    e = sb.pop_front();
    total++;
    if (d !== e.v) begin bad++; $display("FAIL %s: got %0h want %0h", e.nm, d, e.v); end
    e = sb.pop_front();
    total++;
    if (32'(irq) !== e.v) begin bad++; $display("FAIL %s: got %0h want %0h", e.nm, irq, e.v); end
    rd(32'h18, d);
    e = sb.pop_front();
    total++;
    if (d !== e.v) begin bad++; $display("FAIL %s: got %0d want %0d", e.nm, d, e.v); end
  endtask

  task automatic test_small_preset();
    logic [31:0] d;
    exp_t e;
    do_reset();
    bus_write(32'h04, 32'd1);
    bus_write(32'h00, 32'h3);
    for (int i = 0; i < 5; i++) push("preset1_count", (i % 2 == 0) ? 32'd1 : 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      rd(32'h08, d);
      e = sb.pop_front();
      total++;
      if (d !== e.v) begin bad++; $display("FAIL %s step%0d: got %0d want %0d", e.nm, i, d, e.v); end
    end
  endtask

  task automatic test_mask_race();
    logic [31:0] d;
    exp_t e;
    do_reset();
    bus_write(32'h04, 32'd2);
    bus_write(32'h00, 32'h1);
    tick();
    tick();
    tick();
    bus_write(32'h00, 32'h11);
    push("race_ctrl", 32'h11);
    push("race_irq_masked", 32'h0);
    rd(32'h00, d);
    e = sb.pop_front();
    total++;
    if (d !== e.v) begin bad++; $display("FAIL %s: got %0h want %0h", e.nm, d, e.v); end
    e = sb.pop_front();
    total++;
    if (32'(irq) !== e.v) begin bad++; $display("FAIL %s: got %0h want %0h", e.nm, irq, e.v); end
    tick();
    push("race_ctrl_after_int", 32'h10);
    rd(32'h00, d);
    e = sb.pop_front();
    total++;
    if (d !== e.v) begin bad++; $display("FAIL %s: got %0h want %0h", e.nm, d, e.v); end
    bus_write(32'h00, 32'h10);
    push("race_w1c_clear", 32'h0);
    rd(32'h00, d);
    e = sb.pop_front();
    total++;
    if (d !== e.v) begin bad++; $display("FAIL %s: got %0h want %0h", e.nm, d, e.v); end
  endtask

  task automatic test_en_race();
    logic [31:0] d;
    exp_t e;
    do_reset();
    bus_write(32'h14, 32'd1);
    bus_write(32'h10, 32'h1);
    tick();
    tick();
    tick();
    bus_write(32'h10, 32'h1);
    push("enrace_ctrl", 32'h11);
    rd(32'h10, d);
    e = sb.pop_front();
    total++;
    if (d !== e.v) begin bad++; $display("FAIL %s: got %0h want %0h", e.nm, d, e.v); end
    tick();
    tick();
    push("enrace_restart_count", 32'd1);
    rd(32'h18, d);
    e = sb.pop_front();
    total++;
    if (d !== e.v) begin bad++; $display("FAIL %s: got %0d want %0d", e.nm, d, e.v); end
  endtask

  task automatic test_disable();
    logic [31:0] d;
    exp_t e;
    do_reset();
    bus_write(32'h04, 32'd10);
    bus_write(32'h00, 32'h1);
    push("dis_count_pre", 32'd7);
    push("dis_count_frozen", 32'd6);
    push("dis_count_frozen", 32'd6);
    push("dis_count_frozen", 32'd6);
    push("dis_count_latency", 32'd6);
    push("dis_count_restart", 32'd10);
    for (int i = 0; i < 5; i++) tick();
    rd(32'h08, d);
    e = sb.pop_front();
    total++;
    if (d !== e.v) begin bad++; $display("FAIL %s: got %0d want %0d", e.nm, d, e.v); end
    bus_write(32'h00, 32'h0);
    for (int i = 0; i < 3; i++) begin
      rd(32'h08, d);
      e = sb.pop_front();
      total++;
      if (d !== e.v) begin bad++; $display("FAIL %s step%0d: got %0d want %0d", e.nm, i, d, e.v); end
      tick();
    end
    bus_write(32'h00, 32'h1);
    for (int i = 0; i < 2; i++) begin
      tick();
      rd(32'h08, d);
      e = sb.pop_front();
      total++;
      if (d !== e.v) begin bad++; $display("FAIL %s: got %0d want %0d", e.nm, d, e.v); end
    end
  endtask

  task automatic test_preset_midcount();
    logic [31:0] cs [5];
    logic [31:0] d;
    exp_t e;
    cs = '{32'd2, 32'd1, 32'd0, 32'd6, 32'd5};
    do_reset();
    bus_write(32'h14, 32'd4);
    bus_write(32'h10, 32'h3);
    tick();
    tick();
    tick();
    bus_write(32'h14, 32'd6);
    for (int i = 0; i < 5; i++) begin
      push("midpreset_count", cs[i]);
      push("indep_ch0_count", 32'h0);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      rd(32'h18, d);
      e = sb.pop_front();
      total++;
      if (d !== e.v) begin bad++; $display("FAIL %s step%0d: got %0d want %0d", e.nm, i, d, e.v); end
      rd(32'h08, d);
      e = sb.pop_front();
      total++;
      if (d !== e.v) begin bad++; $display("FAIL %s step%0d: got %0d want %0d", e.nm, i, d, e.v); end
    end
    push("midpreset_irq_masked", 32'h0);
    e = sb.pop_front();
    total++;
    if (32'(irq) !== e.v) begin bad++; $display("FAIL %s: got %0h want %0h", e.nm, irq, e.v); end
  endtask

  task automatic test_addr_reset();
    logic [31:0] al [8];
    logic [31:0] d;
    exp_t e;
    al = '{32'h20, 32'h24, 32'h00, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18};
    do_reset();
    bus_write(32'h20, 32'h1);
    bus_write(32'h24, 32'h55);
    bus_write(32'h08, 32'd123);
    bus_write(32'h0C, 32'hFFFF_FFFF);
    bus_if.sel = 1'b0;
    bus_if.we = 1'b1;
    bus_if.addr = 32'h00;
    bus_if.wdata = 32'h9;
    tick();
    bus_if.we = 1'b0;
    for (int i = 0; i < 8; i++) push("addr_ignored", 32'h0);
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      rd(al[i], d);
      e = sb.pop_front();
      total++;
      if (d !== e.v) begin bad++; $display("FAIL %s[%0h]: got %0h want %0h", e.nm, al[i], d, e.v); end
    end
    bus_if.addr = 32'h04;
    push("sel0_rdata", 32'h0);
    bus_write(32'h04, 32'd7);
    bus_if.sel = 1'b0;
    #1;
    e = sb.pop_front();
    total++;
    if (bus_if.rdata !== e.v) begin bad++; $display("FAIL %s: got %0h want %0h", e.nm, bus_if.rdata, e.v); end

    bus_write(32'h04, 32'd100);
    bus_write(32'h00, 32'h9);
    bus_write(32'h14, 32'd1);
    bus_write(32'h10, 32'hB);
    for (int i = 0; i < 5; i++) tick();
    push("pre_reset_irq", 32'h2);
    e = sb.pop_front();
    total++;
    if (32'(irq) !== e.v) begin bad++; $display("FAIL %s: got %0h want %0h", e.nm, irq, e.v); end
    reset = 1'b1;
    #1;
    push("async_reset_irq", 32'h0);
    for (int i = 2; i < 8; i++) push("async_reset_reg", 32'h0);
    e = sb.pop_front();
    total++;
    if (32'(irq) !== e.v) begin bad++; $display("FAIL %s: got %0h want %0h", e.nm, irq, e.v); end
    for (int i = 2; i < 8; i++) begin
      rd(al[i], d);
      e = sb.pop_front();
      total++;
      if (d !== e.v) begin bad++; $display("FAIL %s[%0h]: got %0h want %0h", e.nm, al[i], d, e.v); end
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    push("post_reset_idle_ch0", 32'h0);
    push("post_reset_idle_ch1", 32'h0);
    rd(32'h08, d);
    e = sb.pop_front();
    total++;
    if (d !== e.v) begin bad++; $display("FAIL %s: got %0d want %0d", e.nm, d, e.v); end
    rd(32'h18, d);
    e = sb.pop_front();
    total++;
    if (d !== e.v) begin bad++; $display("FAIL %s: got %0d want %0d", e.nm, d, e.v); end
  endtask

  initial begin
    reset = 1'b1;
    bus_if.sel = 1'b0;
    bus_if.we = 1'b0;
    bus_if.addr = '0;
    bus_if.wdata = '0;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_small_preset();
    test_mask_race();
    test_en_race();
    test_disable();
    test_preset_midcount();
    test_addr_reset();
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
